pulse_cfg_scheduler: RTL and testbench
======================================

# pulse_cfg_scheduler

Configuration controller for the pulse generator. Accepts 32-bit register writes over a valid/ready port and holds them in shadow registers. On a commit it computes the derived pulse edges, validates them against the period, and applies the new set to the generator only at a period boundary, so the generator never runs on a torn configuration. It also runs an optional automatic delay scan, stepping the echo delay every N periods.

## Interface
- DEF_PERIOD, 20000, reset period in clk_pll cycles
- DEF_P1WIDTH, 30, reset pump-pulse width
- DEF_P2WIDTH, 30, reset probe-pulse width
- DEF_DELAY, 200, reset p1-end to p2-start delay
- DEF_ATT_DELAY, 2000, reset sync_up to att_down gap
- DEF_OFFRES_GAP, 8000, subtracted from period for offres_delay
- clk_pll  in  1  single clock
- resetn  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  4  register address
- wr_data  in  32  register data
- cycle_start  in  1  one-cycle strobe from the generator at period start
- period, p1width, delay, p2start, sync_up, att_down, offres_delay  out  32 each  live config
- pump, double  out  1 each  live flags
- pp_pump, pp_probe, post_att  out  7 each  live attenuator words
- cfg_pending  out  1  high from commit accept until apply or reject
- cfg_err  out  1  sticky; last commit rejected

## Operation
- Shadow register map:
  - 0: period
  - 1: p1width
  - 2: p2width
  - 3: delay
  - 4: att_delay
  - 5: flags; bit0 pump, bit1 double
  - 6: attenuators; [6:0] pp_pump, [14:8] pp_probe, [22:16] post_att
  - 7: scan_step
  - 8: scan_count (0 disables scan; a write restarts the scan)
  - 9: scan_hold (periods per step; 0 is treated as 1)
  - 15: commit
  - Other addresses are accepted and ignored.
- FSM states: IDLE, CALC1, CALC2, CALC3, CHECK, ARMED.
- IDLE: wr_ready=1. Writes update shadows. Commit (addr 15) -> CALC1 with cfg_pending=1.
- CALC1: p2start_s = p1width_s + delay_s.
- CALC2: sync_up_s = p2start_s + p2width_s.
- CALC3: att_down_s = sync_up_s + att_delay_s; offres_s = period_s - DEF_OFFRES_GAP + p1width_s.
- All sums are 33-bit. Any carry-out or borrow sets an internal invalid bit.
- CHECK: the commit is invalid if the invalid bit is set, att_down_s >= period_s, or p1width_s == 0.
  - Invalid -> cfg_err=1, cfg_pending=0, return to IDLE. Live outputs are unchanged.
  - Valid -> ARMED.
- ARMED: on a sampled cycle_start, copy all shadows and derived values to the live outputs the same edge, then cfg_err=0, cfg_pending=0, and return to IDLE.
- wr_ready=0 in every state except IDLE. Writes presented then are held off by the handshake, not lost.
- Scan, in IDLE with scan_remaining>0:
  - Count cycle_start strobes.
  - When the count reaches scan_hold: delay_s += scan_step, scan_remaining -= 1, then enter CALC1 as an internal commit.
  - An internal commit that fails CHECK sets cfg_err and clears scan_remaining.
  - A user commit in the same cycle as a scan trigger takes priority; the scan trigger waits for the next cycle_start.

## Timing
- Reset values (outputs and shadows):
  - period 20000, p1width 30, delay 200, p2start 230, sync_up 260, att_down 2260, offres_delay 12030
  - pump 1, double 1
  - pp_pump 0, pp_probe 127, post_att 127
  - cfg_pending 0, cfg_err 0, wr_ready 1
  - FSM in IDLE, scan_remaining 0
- Commit accept to ARMED: 4 cycles.
- Live outputs change only on the clk_pll edge that samples cycle_start in ARMED. They never change mid-period.
- A cycle_start during CALC1..CHECK is not used; apply waits for the next strobe.
- resetn assertion in any state immediately restores all reset values. A pending commit is discarded.

## Test plan
- Reset, then idle 3 periods -> outputs equal the reset values; cycle_start has no effect.
- Write delay=400, commit, then cycle_start after 100 cycles:
  - Outputs unchanged until the strobe.
  - On the strobe edge: delay 400, p2start 430, sync_up 460, att_down 2460.
  - cfg_pending falls on the same edge.
- Write period=2000 (att_down 2260 >= 2000), commit -> cfg_err=1 after CHECK; live period stays 20000; wr_ready returns to 1.
- Write p1width=0xFFFFFFFF, commit -> overflow rejection with cfg_err=1. A following valid commit clears cfg_err on apply.
- scan_step=10, scan_hold=2, scan_count=3:
  - delay steps to 210, 220, 230 on every second cycle_start, then stops.
  - A step whose att_down exceeds period aborts the scan with cfg_err=1.
- Assert resetn low while ARMED -> defaults restored; the commit is never applied after reset release.

Source files
------------

// File: rtl/pulse_cfg_scheduler_if.sv
// Register-write port of the pulse configuration controller.
// Latency: n/a (signal bundle only).
// Backpressure: slave holds wr_ready low while a commit is in flight.
interface pulse_cfg_scheduler_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pulse_cfg_scheduler.sv
// Shadow-register config controller: computes pulse edges on commit, applies at a period boundary, optional delay scan.
// Latency: commit accept to ARMED in 4 cycles; live outputs change on the first cycle_start sampled in ARMED.
// Backpressure: wr_ready is high only in IDLE; writes offered during a commit are stalled, never dropped.
module pulse_cfg_scheduler #(
  parameter logic [31:0] DEF_PERIOD     = 32'd20000,
  parameter logic [31:0] DEF_P1WIDTH    = 32'd30,
  parameter logic [31:0] DEF_P2WIDTH    = 32'd30,
  parameter logic [31:0] DEF_DELAY      = 32'd200,
  parameter logic [31:0] DEF_ATT_DELAY  = 32'd2000,
  parameter logic [31:0] DEF_OFFRES_GAP = 32'd8000
) (
  input  logic                        clk_pll,
  input  logic                        resetn,
  pulse_cfg_scheduler_if.slave        wr,
  input  logic                        cycle_start,
  output logic [31:0]                 period,
  output logic [31:0]                 p1width,
  output logic [31:0]                 delay,
  output logic [31:0]                 p2start,
  output logic [31:0]                 sync_up,
  output logic [31:0]                 att_down,
  output logic [31:0]                 offres_delay,
  output logic                        pump,
  output logic                        double,
  output logic [6:0]                  pp_pump,
  output logic [6:0]                  pp_probe,
  output logic [6:0]                  post_att,
  output logic                        cfg_pending,
  output logic                        cfg_err
);

  localparam logic [31:0] DEF_P2START = DEF_P1WIDTH + DEF_DELAY;
  localparam logic [31:0] DEF_SYNC_UP = DEF_P2START + DEF_P2WIDTH;
  localparam logic [31:0] DEF_ATT_DN  = DEF_SYNC_UP + DEF_ATT_DELAY;
  localparam logic [31:0] DEF_OFFRES  = DEF_PERIOD - DEF_OFFRES_GAP + DEF_P1WIDTH;

  typedef enum logic [2:0] {IDLE, CALC1, CALC2, CALC3, CHECK, ARMED} state_t;
  state_t state_q, state_d;

  // Shadow registers and derived values
  logic [31:0] period_s, p1width_s, p2width_s, delay_s, att_delay_s;
  logic [31:0] p2start_s, sync_up_s, att_down_s, offres_s;
  logic        pump_s, double_s;
  logic [6:0]  pp_pump_s, pp_probe_s, post_att_s;
  logic        inv_q, is_scan;
  logic [31:0] scan_step, scan_rem, scan_hold, hold_cnt;

  logic        wr_fire, user_commit, scan_restart, strobe_idle, hold_hit, scan_trig, commit_bad;
  logic [31:0] hold_eff, delay_base;
  logic [32:0] sum_p2, sum_sync, sum_att, diff_off, sum_off;

  assign wr_fire      = wr.wr_valid && wr.wr_ready;
  assign user_commit  = wr_fire && (wr.wr_addr == 4'd15);
  assign scan_restart = wr_fire && (wr.wr_addr == 4'd8);
  assign hold_eff     = (scan_hold == 32'd0) ? 32'd1 : scan_hold;
  assign hold_hit     = ({1'b0, hold_cnt} + 33'd1) >= {1'b0, hold_eff};
  // A user commit or scan restart in the same cycle defers the scan to the next strobe
  assign strobe_idle  = (state_q == IDLE) && cycle_start && (scan_rem != 32'd0)
                        && !user_commit && !scan_restart;
  assign scan_trig    = strobe_idle && hold_hit;
  assign delay_base   = (wr_fire && wr.wr_addr == 4'd3) ? wr.wr_data : delay_s;

  assign sum_p2   = {1'b0, p1width_s} + {1'b0, delay_s};
  assign sum_sync = {1'b0, p2start_s} + {1'b0, p2width_s};
  assign sum_att  = {1'b0, sync_up_s} + {1'b0, att_delay_s};
  assign diff_off = {1'b0, period_s} - {1'b0, DEF_OFFRES_GAP};
  assign sum_off  = {1'b0, diff_off[31:0]} + {1'b0, p1width_s};
  assign commit_bad = inv_q || (att_down_s >= period_s) || (p1width_s == 32'd0);

  // State register
  always_ff @(posedge clk_pll or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake decode
  always_comb begin
    state_d     = state_q;
    wr.wr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        wr.wr_ready = 1'b1;
        if (user_commit || scan_trig) state_d = CALC1;
      end
      CALC1: state_d = CALC2;
      CALC2: state_d = CALC3;
      CALC3: state_d = CHECK;
      CHECK: state_d = commit_bad ? IDLE : ARMED;
      ARMED: if (cycle_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shadow writes, edge computation pipeline and scan stepping
  always_ff @(posedge clk_pll or negedge resetn) begin
    if (!resetn) begin
      period_s <= DEF_PERIOD;     p1width_s <= DEF_P1WIDTH;   p2width_s <= DEF_P2WIDTH;
      delay_s <= DEF_DELAY;       att_delay_s <= DEF_ATT_DELAY;
      p2start_s <= DEF_P2START;   sync_up_s <= DEF_SYNC_UP;   att_down_s <= DEF_ATT_DN;
      offres_s <= DEF_OFFRES;     pump_s <= 1'b1;             double_s <= 1'b1;
      pp_pump_s <= 7'd0;          pp_probe_s <= 7'd127;       post_att_s <= 7'd127;
      inv_q <= 1'b0;              is_scan <= 1'b0;
      scan_step <= 32'd0;         scan_rem <= 32'd0;          scan_hold <= 32'd0;
      hold_cnt <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_fire) begin
            case (wr.wr_addr)
              4'd0: period_s    <= wr.wr_data;
              4'd1: p1width_s   <= wr.wr_data;
              4'd2: p2width_s   <= wr.wr_data;
              4'd3: delay_s     <= wr.wr_data;
              4'd4: att_delay_s <= wr.wr_data;
              4'd5: begin pump_s <= wr.wr_data[0]; double_s <= wr.wr_data[1]; end
              4'd6: begin
                pp_pump_s  <= wr.wr_data[6:0];
                pp_probe_s <= wr.wr_data[14:8];
                post_att_s <= wr.wr_data[22:16];
              end
              4'd7: scan_step <= wr.wr_data;
              4'd8: begin scan_rem <= wr.wr_data; hold_cnt <= 32'd0; end
              4'd9: scan_hold <= wr.wr_data;
              4'd15: begin inv_q <= 1'b0; is_scan <= 1'b0; end
              default: ;
            endcase
          end
          if (scan_trig) begin
            delay_s  <= delay_base + scan_step;
            scan_rem <= scan_rem - 32'd1;
            hold_cnt <= 32'd0;
            inv_q    <= 1'b0;
            is_scan  <= 1'b1;
          end else if (strobe_idle) begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        CALC1: begin
          p2start_s <= sum_p2[31:0];
          inv_q     <= inv_q | sum_p2[32];
        end
        CALC2: begin
          sync_up_s <= sum_sync[31:0];
          inv_q     <= inv_q | sum_sync[32];
        end
        CALC3: begin
          att_down_s <= sum_att[31:0];
          offres_s   <= sum_off[31:0];
          inv_q      <= inv_q | sum_att[32] | diff_off[32] | sum_off[32];
        end
        CHECK: if (commit_bad && is_scan) scan_rem <= 32'd0;
        default: ;
      endcase
    end
  end

  // Live configuration and status; live set only moves on a period boundary in ARMED
  always_ff @(posedge clk_pll or negedge resetn) begin
    if (!resetn) begin
      period <= DEF_PERIOD;    p1width <= DEF_P1WIDTH;  delay <= DEF_DELAY;
      p2start <= DEF_P2START;  sync_up <= DEF_SYNC_UP;  att_down <= DEF_ATT_DN;
      offres_delay <= DEF_OFFRES;
      pump <= 1'b1;  double <= 1'b1;
      pp_pump <= 7'd0;  pp_probe <= 7'd127;  post_att <= 7'd127;
      cfg_pending <= 1'b0;  cfg_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (user_commit || scan_trig) cfg_pending <= 1'b1;
        CHECK: if (commit_bad) begin cfg_err <= 1'b1; cfg_pending <= 1'b0; end
        ARMED: if (cycle_start) begin
          period <= period_s;    p1width <= p1width_s;  delay <= delay_s;
          p2start <= p2start_s;  sync_up <= sync_up_s;  att_down <= att_down_s;
          offres_delay <= offres_s;
          pump <= pump_s;  double <= double_s;
          pp_pump <= pp_pump_s;  pp_probe <= pp_probe_s;  post_att <= post_att_s;
          cfg_err <= 1'b0;  cfg_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_cfg_scheduler.sv
// Bench for pulse_cfg_scheduler: scenario tasks with a queue of expected live configurations.
// Latency: n/a.
// Backpressure: writes wait on wr_ready with a bounded loop.
module tb_pulse_cfg_scheduler;

  typedef struct packed {
    logic [31:0] period, p1width, delay, p2start, sync_up, att_down, offres;
  } exp_t;

  logic clk, resetn, cycle_start;
  logic [31:0] period, p1width, delay, p2start, sync_up, att_down, offres_delay;
  logic pump, double, cfg_pending, cfg_err;
  logic [6:0] pp_pump, pp_probe, post_att;

  pulse_cfg_scheduler_if bus();

  pulse_cfg_scheduler dut (
    .clk_pll(clk), .resetn(resetn), .wr(bus.slave), .cycle_start(cycle_start),
    .period(period), .p1width(p1width), .delay(delay), .p2start(p2start),
    .sync_up(sync_up), .att_down(att_down), .offres_delay(offres_delay),
    .pump(pump), .double(double), .pp_pump(pp_pump), .pp_probe(pp_probe),
    .post_att(post_att), .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  int n_checks = 0;
  int n_fail = 0;
  exp_t exp_q[$];
  exp_t defs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t calc(logic [31:0] per, logic [31:0] p1w, logic [31:0] p2w,
                                logic [31:0] dly, logic [31:0] attd);
    exp_t e;
    e.period  = per;
    e.p1width = p1w;
    e.delay   = dly;
    e.p2start = p1w + dly;
    e.sync_up = e.p2start + p2w;
    e.att_down = e.sync_up + attd;
    e.offres  = per - 32'd8000 + p1w;
    return e;
  endfunction

  function automatic exp_t snap();
    exp_t s;
    s.period = period;   s.p1width = p1width;   s.delay = delay;
    s.p2start = p2start; s.sync_up = sync_up;   s.att_down = att_down;
    s.offres = offres_delay;
    return s;
  endfunction

  task automatic do_reset();
    resetn = 1'b0; cycle_start = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 32'd0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    while (bus.wr_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL wr_timeout addr=%0d: wr_ready stayed %b, required 1", a, bus.wr_ready);
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic strobe();
    @(negedge clk);
    cycle_start = 1'b1;
    @(negedge clk);
    cycle_start = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    do_reset();
    got = snap();
    n_checks++; if (got !== defs) begin n_fail++; $display("FAIL reset_live got=%h exp=%h", got, defs); end
    n_checks++; if ({pump, double} !== 2'b11) begin n_fail++; $display("FAIL reset_flags got=%b exp=11", {pump, double}); end
    n_checks++; if ({pp_pump, pp_probe, post_att} !== {7'd0, 7'd127, 7'd127}) begin
      n_fail++; $display("FAIL reset_att got=%0d/%0d/%0d exp=0/127/127", pp_pump, pp_probe, post_att); end
    n_checks++; if ({cfg_pending, cfg_err, bus.wr_ready} !== 3'b001) begin
      n_fail++; $display("FAIL reset_status got=%b exp=001", {cfg_pending, cfg_err, bus.wr_ready}); end
    repeat (3) begin strobe(); repeat (20) @(negedge clk); end
    got = snap();
    n_checks++; if (got !== defs) begin n_fail++; $display("FAIL idle_periods got=%h exp=%h", got, defs); end
    n_checks++; if ({cfg_pending, cfg_err} !== 2'b00) begin n_fail++; $display("FAIL idle_status got=%b exp=00", {cfg_pending, cfg_err}); end
  endtask

  task automatic test_commit();
    int changed = 0;
    exp_t got, e;
    do_reset();
    wr(4'd3, 32'd400);
    wr(4'd5, 32'd0);
    wr(4'd6, 32'h0005_0302);
    exp_q.push_back(calc(32'd20000, 32'd30, 32'd30, 32'd400, 32'd2000));
    wr(4'd15, 32'd0);
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL commit_pending got=%b exp=1", cfg_pending); end
    strobe();  // lands while still calculating, must be ignored
    repeat (100) begin
      @(negedge clk);
      if (snap() !== defs || pump !== 1'b1) changed++;
    end
    n_checks++; if (changed !== 0) begin n_fail++; $display("FAIL commit_early_change got=%0d cycles changed exp=0", changed); end
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL commit_still_pending got=%b exp=1", cfg_pending); end
    strobe();
    got = snap();
    e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL commit_apply got=%h exp=%h", got, e); end
    n_checks++; if ({pump, double, pp_pump, pp_probe, post_att} !== {2'b00, 7'd2, 7'd3, 7'd5}) begin
      n_fail++; $display("FAIL commit_flags got=%b/%0d/%0d/%0d exp=00/2/3/5", {pump, double}, pp_pump, pp_probe, post_att); end
    n_checks++; if ({cfg_pending, cfg_err} !== 2'b00) begin n_fail++; $display("FAIL commit_status got=%b exp=00", {cfg_pending, cfg_err}); end
  endtask

  task automatic test_reject();
    exp_t got;
    do_reset();
    wr(4'd0, 32'd2000);
    wr(4'd15, 32'd0);
    repeat (6) @(negedge clk);
    n_checks++; if ({cfg_err, cfg_pending, bus.wr_ready} !== 3'b101) begin
      n_fail++; $display("FAIL reject_status got=%b exp=101", {cfg_err, cfg_pending, bus.wr_ready}); end
    strobe();
    got = snap();
    n_checks++; if (got !== defs) begin n_fail++; $display("FAIL reject_live got=%h exp=%h", got, defs); end
  endtask

  task automatic test_overflow();
    exp_t got, e;
    do_reset();
    wr(4'd1, 32'hFFFF_FFFF);
    wr(4'd15, 32'd0);
    repeat (6) @(negedge clk);
    n_checks++; if ({cfg_err, cfg_pending} !== 2'b10) begin n_fail++; $display("FAIL ovf_reject got=%b exp=10", {cfg_err, cfg_pending}); end
    wr(4'd1, 32'd40);
    exp_q.push_back(calc(32'd20000, 32'd40, 32'd30, 32'd200, 32'd2000));
    wr(4'd15, 32'd0);
    repeat (6) @(negedge clk);
    n_checks++; if ({cfg_err, cfg_pending} !== 2'b11) begin n_fail++; $display("FAIL ovf_armed got=%b exp=11", {cfg_err, cfg_pending}); end
    strobe();
    got = snap();
    e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL ovf_apply got=%h exp=%h", got, e); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_clear got=%b exp=0", cfg_err); end
  endtask

  // Runs strobes; every change of the live set must match the next queued expectation.
  task automatic run_strobes(input int n, input string tag);
    exp_t prev, got, e;
    prev = snap();
    for (int i = 0; i < n; i++) begin
      strobe();
      repeat (12) @(negedge clk);
      got = snap();
      if (got !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s_unexpected got=%h exp=%h", tag, got, prev);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL %s_step got=%h exp=%h", tag, got, e); end
        end
      end
      prev = got;
    end
  endtask

  task automatic test_scan();
    do_reset();
    exp_q.push_back(calc(32'd20000, 32'd30, 32'd30, 32'd210, 32'd2000));
    exp_q.push_back(calc(32'd20000, 32'd30, 32'd30, 32'd220, 32'd2000));
    exp_q.push_back(calc(32'd20000, 32'd30, 32'd30, 32'd230, 32'd2000));
    wr(4'd7, 32'd10);
    wr(4'd9, 32'd2);
    wr(4'd8, 32'd3);
    run_strobes(14, "scan");
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scan_left got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    n_checks++; if (delay !== 32'd230) begin n_fail++; $display("FAIL scan_final_delay got=%0d exp=230", delay); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL scan_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_scan_abort();
    exp_t got, e;
    do_reset();
    wr(4'd4, 32'd19725);
    exp_q.push_back(calc(32'd20000, 32'd30, 32'd30, 32'd200, 32'd19725));
    wr(4'd15, 32'd0);
    repeat (6) @(negedge clk);
    strobe();
    got = snap();
    e = exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL abort_base got=%h exp=%h", got, e); end
    exp_q.push_back(calc(32'd20000, 32'd30, 32'd30, 32'd210, 32'd19725));
    wr(4'd7, 32'd10);
    wr(4'd9, 32'd0);
    wr(4'd8, 32'd3);
    run_strobes(8, "abort");
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_left got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    n_checks++; if ({cfg_err, cfg_pending} !== 2'b10) begin n_fail++; $display("FAIL abort_status got=%b exp=10", {cfg_err, cfg_pending}); end
    n_checks++; if (delay !== 32'd210) begin n_fail++; $display("FAIL abort_delay got=%0d exp=210", delay); end
  endtask

  task automatic test_reset_armed();
    exp_t got;
    do_reset();
    wr(4'd3, 32'd400);
    wr(4'd15, 32'd0);
    repeat (5) @(negedge clk);
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL armed_pending got=%b exp=1", cfg_pending); end
    resetn = 1'b0;
    #1;
    got = snap();
    n_checks++; if (got !== defs) begin n_fail++; $display("FAIL rst_async_live got=%h exp=%h", got, defs); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL rst_async_pending got=%b exp=0", cfg_pending); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    strobe();
    repeat (10) @(negedge clk);
    strobe();
    got = snap();
    n_checks++; if (got !== defs) begin n_fail++; $display("FAIL rst_discard got=%h exp=%h", got, defs); end
    n_checks++; if ({cfg_pending, bus.wr_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_status got=%b exp=01", {cfg_pending, bus.wr_ready}); end
  endtask

  initial begin
    defs = calc(32'd20000, 32'd30, 32'd30, 32'd200, 32'd2000);
    test_reset();
    test_commit();
    test_reject();
    test_overflow();
    test_scan();
    test_scan_abort();
    test_reset_armed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
